// File: rtl/mul_seq_pkg.sv
// Shared constants for the radix-4 Booth multiply sequencer: FSM encodings,
// partial-product select codes and the Booth recoding helper.
package mul_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] SEL_ZERO = 3'd0;
    localparam logic [2:0] SEL_P1   = 3'd1;
    localparam logic [2:0] SEL_P2   = 3'd2;
    localparam logic [2:0] SEL_M1   = 3'd3;
    localparam logic [2:0] SEL_M2   = 3'd4;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}.
    function automatic logic [2:0] booth_sel(input logic [2:0] trip);
        logic [2:0] sel;
        case (trip)
            3'b001, 3'b010: sel = SEL_P1;
            3'b011:         sel = SEL_P2;
            3'b100:         sel = SEL_M2;
            3'b101, 3'b110: sel = SEL_M1;
            default:        sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product selector: maps a multiplier triplet to
// 0, +/-mcand or +/-2*mcand, sign-extended to W+2 bits.
module booth_pp_sel
    import mul_seq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   triplet,
    input  logic [W-1:0] mcand,
    output logic [W+1:0] pp
);

    logic [W+1:0] m_ext;
    logic [2:0]   sel;

    assign m_ext = {{2{mcand[W-1]}}, mcand};
    assign sel   = booth_sel(triplet);

    // W+2 bits hold 2*mcand and -2*mcand for every input, including the most negative one.
    always_comb begin
        pp = '0;
        case (sel)
            SEL_P1:  pp = m_ext;
            SEL_P2:  pp = m_ext << 1;
            SEL_M1:  pp = -m_ext;
            SEL_M2:  pp = -(m_ext << 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative radix-4 Booth multiply sequencer: one bit-pair per clock for W/2
// cycles, 2W-bit product on hi/lo with a one-cycle done pulse.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = 5
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int PW = 2 * W;
    localparam logic [CW-1:0] LAST = CW'(W / 2 - 1);

    logic [1:0]    state;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic          prev;
    logic [PW-1:0] acc;
    logic [CW-1:0] count;
    logic [W+1:0]  pp;
    logic [PW-1:0] pp_shift;
    logic [PW-1:0] sum;

    // mplier shifts right two bits per iteration, so bits [1:0] are always
    // b[2i+1:2i] and prev carries b[2i-1].
    booth_pp_sel #(.W(W)) u_pp_sel (
        .triplet ({mplier[1:0], prev}),
        .mcand   (mcand),
        .pp      (pp)
    );

    always_comb begin
        pp_shift = {{(PW - W - 2){pp[W+1]}}, pp} << {count, 1'b0};
        sum      = acc + pp_shift;
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= ST_IDLE;
            mcand  <= '0;
            mplier <= '0;
            prev   <= 1'b0;
            acc    <= '0;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    acc    <= sum;
                    count  <= count + 1'b1;
                    prev   <= mplier[1];
                    mplier <= {2'b00, mplier[W-1:2]};
                    if (count == LAST) begin
                        {hi, lo} <= sum;
                        state    <= ST_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        prev   <= 1'b0;
                        acc    <= '0;
                        count  <= '0;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed cases with literal results
// plus randomized traffic against a transaction-level product/timing model.
module tb_mul_seq_ctrl;

    localparam int W  = 32;
    localparam int CW = 5;
    localparam int N  = W / 2;

    logic         clk   = 1'b0;
    logic         clr_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int vectors     = 0;
    int miscompares = 0;

    // Model: an operation in flight with a countdown; result is plain a*b.
    bit              m_busy = 1'b0;
    bit              m_done = 1'b0;
    int              m_left = 0;
    logic [2*W-1:0]  m_prod = '0;
    logic [2*W-1:0]  m_out  = '0;

    mul_seq_ctrl #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] product(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return sx * sy;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
            m_out  = '0;
        end else if (m_busy) begin
            m_done = 1'b0;
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_out  = m_prod;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_prod = product(a, b);
                m_busy = 1'b1;
                m_left = N;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("hi", 64'(hi), 64'(m_out[2*W-1:W]));
        chk("lo", 64'(lo), 64'(m_out[W-1:0]));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int limit, output int busy_cycles, output int waited);
        bit seen;
        seen        = 1'b0;
        busy_cycles = 0;
        waited      = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            waited++;
            if (done) seen = 1'b1;
            else if (busy) busy_cycles++;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done within %0d cycles, expected one", limit);
        end
    endtask

    task automatic count_dones(input string name, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk(name, 64'(n), 64'd0);
    endtask

    task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
        int bc;
        int wt;
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        wait_done(40, bc, wt);
        chk({name, " busy_cycles"}, 64'(bc), 64'(N));
        chk({name, " hi"}, 64'(hi), 64'(eh));
        chk({name, " lo"}, 64'(lo), 64'(el));
        chk({name, " model"}, m_out, {eh, el});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int wt;

        tick();
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hilo", {hi, lo}, 64'd0);
        tick();
        clr_n = 1'b1;
        tick();

        run_op("7x-3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("maxxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
        run_op("0x12345", 32'd0, 32'd12345, 32'h0, 32'h0);

        // Second start during RUN must be dropped.
        a = 32'd5; b = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40, bc, wt);
        chk("5x6 lo", 64'(lo), 64'd30);
        chk("5x6 hi", 64'(hi), 64'd0);
        count_dones("5x6 no_second_done", 25);

        // Start held through DONE: back-to-back operations.
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        wait_done(40, bc, wt);
        chk("-1x-1 lo", 64'(lo), 64'd1);
        chk("-1x-1 hi", 64'(hi), 64'd0);
        a = 32'd2; b = 32'hFFFF_FFFC;
        wait_done(40, bc, wt);
        start = 1'b0;
        chk("b2b gap", 64'(wt), 64'(N + 1));
        chk("2x-4 hi", 64'(hi), 64'hFFFF_FFFF);
        chk("2x-4 lo", 64'(lo), 64'hFFFF_FFF8);

        // Reset in the middle of RUN.
        @(negedge clk);
        a = 32'd11; b = 32'd13; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        tick();
        clr_n = 1'b0;
        #1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        chk("midreset hilo", {hi, lo}, 64'd0);
        tick(); tick();
        clr_n = 1'b1;
        count_dones("midreset no_done", 25);

        run_op("3x4", 32'd3, 32'd4, 32'h0, 32'd12);

        // Randomized traffic: stray starts, corner operands, occasional reset.
        for (int i = 0; i < 2000; i++) begin
            tick();
            start = ($urandom_range(3) == 0);
            a     = pick();
            b     = pick();
            clr_n = ($urandom_range(299) != 0);
        end
        tick();
        clr_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Iterative radix-4 Booth multiply sequencer for the ALU MUL path.
- Captures signed operands on a start handshake and retires one Booth bit-pair per clock, for W/2 cycles.
- Accumulates the 2W-bit product and presents it as HI/LO with a one-cycle done pulse.
- Replaces the fully unrolled combinational multiplier in the CPU control sequence, so the control unit can stall on busy.

Parameters:
- W, 32, operand width in bits; must be even and at least 4.
- CW, 5, iteration counter width; must satisfy 2^CW >= W/2.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  W  multiplicand, signed two's complement.
- b  in  W  multiplier, signed two's complement.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; hi and lo are valid from this cycle.
- hi  out  W  product bits [2W-1:W].
- lo  out  W  product bits [W-1:0].

Behaviour:
- Reset: clr_n low asynchronously forces state=IDLE, busy=0, done=0, hi=0, lo=0, count=0, accumulator=0 and operand registers=0.
- Reset mid-RUN abandons the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Latch a into mcand and b into mplier; prev=0; acc=0; count=0.
  - Go to RUN.
- RUN, each edge, iteration i=count:
  - Triplet = {mplier[2i+1], mplier[2i], prev}, where prev = mplier[2i-1] (0 for i=0).
  - Partial product selection: 000/111 -> 0; 001/010 -> +mcand; 011 -> +2*mcand; 100 -> -2*mcand; 101/110 -> -mcand.
  - Sign-extend the partial product to 2W, shift left by 2i, add to acc modulo 2^(2W).
  - Increment count.
  - At i = W/2-1: load {hi,lo} with the final sum and go to DONE.
- Latency: start accepted at edge k -> done=1 in the cycle following edge k+W/2 (16 cycles for W=32).
- busy is high for exactly W/2 cycles.
- DONE lasts one cycle with done=1.
  - Next edge: start=1 -> recapture operands and go to RUN (back-to-back, no IDLE bubble).
  - Otherwise go to IDLE.
- start in RUN is ignored and not queued.
- Operand inputs are don't-care except at the accepting edge.
- hi/lo hold the last product until the next DONE or reset; they never show partial sums.
- -mcand is two's complement.
  - Negating the most negative value is not special-cased; it is correct because the arithmetic is carried in 2W-bit sign-extended form.
- No overflow flag; the full 2W-bit product is always exact.

Decomposition:
- Package mul_seq_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Booth select codes SEL_ZERO, SEL_P1, SEL_P2, SEL_M1, SEL_M2.
- One sub-module, booth_pp_sel (combinational):
  - Inputs: triplet, mcand.
  - Output: sign-extended (W+2)-bit partial product.
  - The controller owns shifting, accumulation and the FSM.

Test Plan:
- a=7, b=-3, start pulse -> busy high 16 cycles; done pulse; hi=FFFFFFFF, lo=FFFFFFEB.
- a=32'h80000000, b=32'h80000000 -> hi=40000000, lo=00000000.
- a=32'h7FFFFFFF, b=32'h7FFFFFFF -> hi=3FFFFFFF, lo=00000001; then a=0, b=12345 -> hi=0, lo=0.
- Start a=5, b=6; pulse start again at cycle 4 with a=9, b=9 -> single done with lo=30; no second done.
- Start held high through DONE with a=-1, b=-1, then a=2, b=-4 -> done pulses 17 cycles apart; results lo=1 then hi=FFFFFFFF, lo=FFFFFFF8.
- clr_n low at cycle 8 of RUN -> busy, done, hi and lo all 0 immediately; no done after release.
- Next start a=3, b=4 -> lo=12.
